// File: rtl/intcode_io_fifo_port.sv
// Memory-mapped FIFO I/O responder for the intcode CPU bus.
// Host->CPU input FIFO, CPU->host output FIFO, sticky status flags.
module intcode_io_fifo_port #(
  parameter int          IN_DEPTH    = 16,
  parameter int          OUT_DEPTH   = 16,
  parameter logic [31:0] IN_ADDR     = 32'hFFFF0000,
  parameter logic [31:0] OUT_ADDR    = 32'hFFFF0001,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF0002
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic        ram_write,
  inout  wire  [31:0] data_bus,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        irq_in_avail
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;

  logic [31:0]    r_in_mem  [IN_DEPTH];
  logic [31:0]    r_out_mem [OUT_DEPTH];
  logic [IAW-1:0] r_in_wr;
  logic [IAW-1:0] r_in_rd;
  logic [ICW-1:0] r_in_count;
  logic [OAW-1:0] r_out_wr;
  logic [OAW-1:0] r_out_rd;
  logic [OCW-1:0] r_out_count;
  logic           r_in_uf;
  logic           r_out_of;
  logic           r_sel_in_q;
  logic           r_wr_q;

  logic        w_sel_in;
  logic        w_sel_st;
  logic        w_wr_rise;
  logic        w_cpu_pop;
  logic        w_cpu_push;
  logic        w_clr;
  logic        w_in_empty;
  logic        w_out_full;
  logic        w_in_push;
  logic        w_in_pop;
  logic        w_out_push;
  logic        w_out_pop;
  logic [31:0] w_in_head;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_drive;

  assign w_sel_in   = (address_bus == IN_ADDR) && !ram_write;
  assign w_sel_st   = (address_bus == STATUS_ADDR) && !ram_write;
  assign w_wr_rise  = ram_write && !r_wr_q;
  assign w_cpu_pop  = r_sel_in_q && !w_sel_in;
  assign w_cpu_push = w_wr_rise && (address_bus == OUT_ADDR);
  assign w_clr      = w_wr_rise && (address_bus == STATUS_ADDR);

  assign w_in_empty = (r_in_count == '0);
  assign w_out_full = (r_out_count == OCW'(OUT_DEPTH));

  assign in_ready     = (r_in_count != ICW'(IN_DEPTH));
  assign out_valid    = (r_out_count != '0);
  assign irq_in_avail = !w_in_empty;

  assign w_in_push  = in_valid && in_ready;
  assign w_in_pop   = w_cpu_pop && !w_in_empty;
  assign w_out_push = w_cpu_push && !w_out_full;
  assign w_out_pop  = out_valid && out_ready;

  assign w_in_head = w_in_empty ? 32'd0 : r_in_mem[r_in_rd];
  assign out_data  = out_valid ? r_out_mem[r_out_rd] : 32'd0;

  assign w_status = {r_in_uf, r_out_of, 14'd0,
                     8'(r_out_count), 8'(r_in_count)};

  assign w_drive  = w_sel_in || w_sel_st;
  assign w_rdata  = w_sel_in ? w_in_head : w_status;
  assign data_bus = w_drive ? w_rdata : 32'bz;

  // Bus edge detectors: read-select history and write-strobe history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sel_in_q <= 1'b0;
      r_wr_q     <= 1'b0;
    end else begin
      r_sel_in_q <= w_sel_in;
      r_wr_q     <= ram_write;
    end
  end

  // Input FIFO storage written by the host
  always_ff @(posedge clock) begin
    if (w_in_push && !reset)
      r_in_mem[r_in_wr] <= in_data;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_in_count <= '0;
    end else begin
      if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
      if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
      unique case ({w_in_push, w_in_pop})
        2'b10:   r_in_count <= r_in_count + 1'b1;
        2'b01:   r_in_count <= r_in_count - 1'b1;
        default: r_in_count <= r_in_count;
      endcase
    end
  end

  // Output FIFO storage written by the CPU
  always_ff @(posedge clock) begin
    if (w_out_push && !reset)
      r_out_mem[r_out_wr] <= data_bus;
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_out_count <= '0;
    end else begin
      if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
      if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
      unique case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + 1'b1;
        2'b01:   r_out_count <= r_out_count - 1'b1;
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  // Sticky error flags; a set at the same edge beats a clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_uf  <= 1'b0;
      r_out_of <= 1'b0;
    end else begin
      if (w_cpu_pop && w_in_empty) r_in_uf <= 1'b1;
      else if (w_clr)              r_in_uf <= 1'b0;
      if (w_cpu_push && w_out_full) r_out_of <= 1'b1;
      else if (w_clr)               r_out_of <= 1'b0;
    end
  end

endmodule
